// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter for 8 requesters with a done handshake and a per-grant hold timeout.
// The grant is presented as a registered index and as a matching one-hot vector.
module rr_onehot_arbiter #(
    parameter int N_REQ    = 8,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [N_REQ-1:0]           req,
    input  logic                       done,
    output logic                       grant_valid,
    output logic [$clog2(N_REQ)-1:0]   grant_idx,
    output logic [N_REQ-1:0]           grant,
    output logic                       timeout
);
    localparam int IW = $clog2(N_REQ);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           st_q, st_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gv_d, to_d;
    logic [IW-1:0]    idx_d;
    logic [N_REQ-1:0] gnt_d;

    // Requests rotated so that bit k is requester (ptr + k); lowest set bit wins.
    logic [N_REQ-1:0] rot;
    logic [IW-1:0]    pick_ofs, pick;

    for (genvar k = 0; k < N_REQ; k++) begin : g_rot
        assign rot[k] = req[ptr_q + IW'(k)];
    end

    always_comb begin
        pick_ofs = '0;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (rot[k]) pick_ofs = IW'(k);
        pick = ptr_q + pick_ofs;
    end

    always_comb begin
        st_d  = st_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        gv_d  = grant_valid;
        idx_d = grant_idx;
        gnt_d = grant;
        to_d  = 1'b0;
        case (st_q)
            IDLE: begin
                if (en && (|req)) begin
                    idx_d = pick;
                    gnt_d = {{(N_REQ-1){1'b0}}, 1'b1} << pick;
                    gv_d  = 1'b1;
                    cnt_d = '0;
                    st_d  = GRANT;
                end
            end
            GRANT: begin
                if (!en || done || !req[grant_idx] || cnt_q == CNT_W'(MAX_HOLD - 1)) begin
                    gv_d  = 1'b0;
                    gnt_d = '0;
                    ptr_d = grant_idx + 1'b1;
                    st_d  = IDLE;
                    // Only a pure hold-limit release reports a timeout.
                    to_d  = en && !done && req[grant_idx];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q        <= IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            grant       <= '0;
            timeout     <= 1'b0;
        end else begin
            st_q        <= st_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            grant_valid <= gv_d;
            grant_idx   <= idx_d;
            grant       <= gnt_d;
            timeout     <= to_d;
        end
    end
endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed + randomized bench for rr_onehot_arbiter, checked against a cycle-level
// reference model that tracks owner, pointer and cycles-held as plain integers.
module tb_rr_onehot_arbiter;
    localparam int MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] req = '0;
    logic       done = 1'b0;
    logic       grant_valid;
    logic [2:0] grant_idx;
    logic [7:0] grant;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit m_gv;
    int m_idx, m_ptr, m_held;
    bit m_to;

    rr_onehot_arbiter #(.N_REQ(8), .MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .done(done),
        .grant_valid(grant_valid), .grant_idx(grant_idx), .grant(grant), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input bit e, input bit [7:0] r, input bit d, input bit rn);
        if (!rn) begin
            m_gv = 0; m_idx = 0; m_ptr = 0; m_held = 0; m_to = 0;
        end else if (!m_gv) begin
            m_to = 0;
            if (e && r != 0) begin
                for (int j = 0; j < 8; j++) begin
                    int c;
                    c = (m_ptr + j) % 8;
                    if (!m_gv && r[c]) begin
                        m_gv = 1; m_idx = c; m_held = 1;
                    end
                end
            end
        end else begin
            m_to = 0;
            if (!e || d || !r[m_idx]) begin
                m_gv = 0; m_ptr = (m_idx + 1) % 8;
            end else if (m_held == MAX_HOLD) begin
                m_gv = 0; m_ptr = (m_idx + 1) % 8; m_to = 1;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic step(input bit e, input bit [7:0] r, input bit d, input bit rn);
        logic [7:0] exp_g;
        en = e; req = r; done = d; rst_n = rn;
        @(posedge clk);
        model_edge(e, r, d, rn);
        #1;
        exp_g = m_gv ? (8'h01 << m_idx) : 8'h00;
        chk("grant_valid", 32'(grant_valid), 32'(m_gv));
        chk("grant_idx", 32'(grant_idx), 32'(m_idx));
        chk("grant", 32'(grant), 32'(exp_g));
        chk("timeout", 32'(timeout), 32'(m_to));
    endtask

    initial begin
        int n;
        // reset, then a single request from requester 2
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_idx", 32'(grant_idx), 32'h0);
        step(1, 8'h04, 0, 1);
        chk("single_grant", 32'(grant), 32'h04);
        chk("single_idx", 32'(grant_idx), 32'd2);
        step(1, 8'h04, 0, 1);
        step(1, 8'h04, 0, 1);
        step(1, 8'h04, 1, 1);
        chk("single_release", 32'(grant), 32'h0);
        step(1, 8'hFF, 0, 1);
        chk("single_ptr3", 32'(grant_idx), 32'd3);
        step(1, 8'hFF, 1, 1);

        // round robin with everyone requesting
        step(1, 8'h00, 0, 0);
        for (int k = 0; k < 9; k++) begin
            step(1, 8'hFF, 0, 1);
            chk("rr_idx", 32'(grant_idx), 32'(k % 8));
            step(1, 8'hFF, 1, 1);
            chk("rr_bubble", 32'(grant_valid), 32'h0);
        end

        // hold timeout
        step(1, 8'h00, 0, 0);
        step(1, 8'h01, 0, 1);
        n = 1;
        for (int k = 0; k < 20; k++) begin
            step(1, 8'h01, 0, 1);
            if (grant_valid) n++;
            else break;
        end
        chk("to_len", 32'(n), 32'(MAX_HOLD));
        chk("to_pulse", 32'(timeout), 32'h1);
        step(1, 8'h01, 0, 1);
        chk("to_pulse_clear", 32'(timeout), 32'h0);
        chk("to_regrant", 32'(grant), 32'h01);

        // release causes outrank the timeout
        step(1, 8'h00, 0, 0);
        step(1, 8'h01, 0, 1);
        for (int k = 0; k < MAX_HOLD - 1; k++) step(1, 8'h01, 0, 1);
        chk("prio_still_held", 32'(grant_valid), 32'h1);
        step(0, 8'h01, 1, 1);
        chk("prio_release", 32'(grant_valid), 32'h0);
        chk("prio_no_to", 32'(timeout), 32'h0);

        // pointer wrap from 7 to 0
        step(1, 8'h00, 0, 0);
        step(1, 8'h80, 0, 1);
        chk("wrap_own7", 32'(grant_idx), 32'd7);
        step(1, 8'h81, 1, 1);
        step(1, 8'h81, 0, 1);
        chk("wrap_idx0", 32'(grant_idx), 32'd0);

        // request drop, then reset mid-grant
        step(1, 8'h00, 0, 0);
        step(1, 8'h20, 0, 1);
        step(1, 8'h20, 0, 1);
        step(1, 8'h00, 0, 1);
        chk("drop_release", 32'(grant_valid), 32'h0);
        chk("drop_no_to", 32'(timeout), 32'h0);
        step(1, 8'h03, 0, 1);
        chk("drop_next", 32'(grant_idx), 32'd0);
        step(1, 8'h03, 0, 0);
        chk("midrst_grant", 32'(grant), 32'h0);
        chk("midrst_idx", 32'(grant_idx), 32'h0);
        step(1, 8'h81, 0, 1);
        chk("midrst_ptr0", 32'(grant_idx), 32'd0);

        // randomized traffic
        for (int k = 0; k < 400; k++)
            step(($urandom_range(0, 9) != 0), 8'($urandom),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 60) != 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
